slew_ramp_ctrl: RTL and testbench
=================================

SLEW_RAMP_CTRL -- requirements
Module: slew_ramp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 12, which sets the output code width in bits.
REQ-002 SHALL have parameter TW, default 8, which sets the width of the period and settle counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request that latches target, step_up, step_dn, period and settle.
REQ-006 SHALL have port abort  input  1  stops the ramp immediately.
REQ-007 SHALL have port target  input  WIDTH  code to ramp toward.
REQ-008 SHALL have port step_up / step_dn  input  WIDTH  maximum rise / fall per step.
REQ-009 SHALL have port period / settle  input  TW  cycles per step / settle cycles after target is reached.
REQ-010 SHALL have port dac_code  output  WIDTH  registered DAC code.
REQ-011 SHALL have port busy  output  1  high in RAMP or SETTLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a ramp completes.
REQ-013 SHALL have port dir  output  1  1 = rising, 0 = falling or equal; valid while busy.

Function
REQ-014 SHALL implement FSM states IDLE, RAMP and SETTLE.
REQ-015 SHALL, on start in any state, latch all inputs, clear the step timer, and enter RAMP; if the latched target equals dac_code it SHALL enter SETTLE instead.
REQ-016 SHALL treat period=0 as 1, and step_up=0 or step_dn=0 as 1 (progress guaranteed).
REQ-017 SHALL count the step timer from 0 to period-1; a step occurs on the cycle it equals period-1, and it then wraps to 0.
REQ-018 SHALL make the first step happen exactly period cycles after RAMP is entered.
REQ-019 SHALL compute rising steps as dac_code <= min(dac_code+step_up, target) in WIDTH+1 bits, with no wrap-around.
REQ-020 SHALL compute falling steps as dac_code <= max(dac_code-step_dn, target) in WIDTH+1 signed bits, with no underflow.
REQ-021 SHALL move RAMP to SETTLE on the same edge that the step makes dac_code equal target.
REQ-022 SHALL stay in SETTLE for settle cycles (settle=0 means exit on the next edge), then go to IDLE and pulse done for 1 cycle.
REQ-023 SHALL, on abort, go to IDLE on the next edge with dac_code held, no done, and busy low.
REQ-024 SHALL give abort priority over start when both are asserted in the same cycle.
REQ-025 SHALL treat start in SETTLE as a retarget: return to RAMP (or restart SETTLE if target is unchanged).
REQ-026 SHALL not change dac_code in IDLE.

Reset
REQ-027 SHALL, on rst_n low, immediately set the state to IDLE, dac_code=0, busy=0, done=0, dir=0, timers=0 and latched registers=0.
REQ-028 SHALL, on reset mid-ramp, abandon the ramp with no done pulse.
REQ-029 SHALL resume operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with SLEW_RAMP_CTRL_CROSS_EN defined, add input cross_thr (WIDTH) and outputs cross_evt (1) and cross_dir (1).
REQ-031 SHALL, with the macro defined, pulse cross_evt for 1 cycle when a step satisfies old<thr<=new (cross_dir=1) or old>=thr>new (cross_dir=0).
REQ-032 SHALL, with the macro defined, reset cross_evt and cross_dir to 0.
REQ-033 SHALL, without SLEW_RAMP_CTRL_CROSS_EN, omit these ports and their logic entirely.

Verification
REQ-034 SHALL cover: code 0, start target=10, step_up=4, period=1, settle=2 -> dac_code 4, 8, 10 on consecutive edges, then 2 SETTLE cycles, then done pulse, busy=0.
REQ-035 SHALL cover: code 10, target=3, step_dn=5, period=3 -> dac_code 5 at 3 cycles after RAMP, 3 at 6 cycles, dir=0.
REQ-036 SHALL cover: WIDTH=12, code 4090, target=4095, step_up=4000 -> dac_code=4095 with no wrap; code 5, target 0, step_dn=100 -> 0.
REQ-037 SHALL cover: abort and start in the same cycle mid-ramp at code 8 -> IDLE, dac_code=8, no done.
REQ-038 SHALL cover: rst_n low mid-ramp -> outputs 0 asynchronously; start with target=dac_code -> SETTLE directly, then done after settle cycles.
REQ-039 SHALL cover, with SLEW_RAMP_CTRL_CROSS_EN: cross_thr=6, ramp 0->10 with step 4 -> cross_evt on the 4->8 step, cross_dir=1.

Source files
------------

// File: rtl/slew_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// slew_ramp_ctrl
//
// Slew-rate limited DAC code ramp controller. A start request latches a target
// code, separate maximum rise/fall step sizes, a step period and a settle time.
// The registered DAC code then moves toward the target by at most one step
// every 'period' cycles. It never overshoots the target and never wraps. Once
// the target is reached, the block waits 'settle' cycles and then pulses done.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      one-cycle request; latches target/steps/period/settle
//   abort      in   1      stop immediately; wins over start
//   target     in   WIDTH  code to ramp toward
//   step_up    in   WIDTH  maximum rise per step (0 is treated as 1)
//   step_dn    in   WIDTH  maximum fall per step (0 is treated as 1)
//   period     in   TW     cycles per step (0 is treated as 1)
//   settle     in   TW     settle cycles after the target is reached
//   dac_code   out  WIDTH  registered DAC code
//   busy       out  1      high while ramping or settling
//   done       out  1      one-cycle pulse when a ramp completes
//   dir        out  1      1 = rising, 0 = falling or equal; valid while busy
//
// Optional feature (macro SLEW_RAMP_CTRL_CROSS_EN)
//   cross_thr  in   WIDTH  threshold watched during steps
//   cross_evt  out  1      one-cycle pulse when a step crosses cross_thr
//   cross_dir  out  1      1 = crossed upward, 0 = crossed downward
// -----------------------------------------------------------------------------
module slew_ramp_ctrl #(
  parameter int WIDTH = 12,
  parameter int TW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] step_up,
  input  logic [WIDTH-1:0] step_dn,
  input  logic [TW-1:0]    period,
  input  logic [TW-1:0]    settle,
`ifdef SLEW_RAMP_CTRL_CROSS_EN
  input  logic [WIDTH-1:0] cross_thr,
  output logic             cross_evt,
  output logic             cross_dir,
`endif
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic             dir
);

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [TW-1:0]    ONE_T = TW'(1);
  localparam logic [TW:0]      ONE_T1 = (TW+1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // Latched request parameters
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] up_q;
  logic [WIDTH-1:0] dn_q;
  logic [TW-1:0]    per_q;
  logic [TW-1:0]    set_q;

  // Timers
  logic [TW-1:0]    step_tmr;
  logic [TW-1:0]    settle_tmr;

  // Step datapath
  logic [WIDTH:0]        sum_up;
  logic signed [WIDTH:0] diff_dn;
  logic [WIDTH-1:0]      step_next;
  logic [TW-1:0]         per_last;
  logic                  step_fire;
  logic                  reached;
  logic                  settle_end;

  // Step arithmetic is done one bit wider than the code, so a large rise
  // cannot wrap past full scale and a large fall shows up as a negative
  // value instead of an underflow. Each result is then clamped to the target.
  always_comb begin
    sum_up    = {1'b0, dac_code} + {1'b0, up_q};
    diff_dn   = $signed({1'b0, dac_code}) - $signed({1'b0, dn_q});
    step_next = dac_code;
    if (dir) begin
      if (sum_up > {1'b0, tgt_q}) begin
        step_next = tgt_q;
      end else begin
        step_next = sum_up[WIDTH-1:0];
      end
    end else begin
      if (diff_dn < $signed({1'b0, tgt_q})) begin
        step_next = tgt_q;
      end else begin
        step_next = diff_dn[WIDTH-1:0];
      end
    end
  end

  // The step timer runs 0..period-1 and a step fires on the last count.
  // Because the timer is cleared on entry to RAMP, the first step lands
  // exactly 'period' cycles after entry. per_q is never 0 inside RAMP,
  // because start replaces 0 with 1 when it latches the period.
  // settle_end uses TW+1 bits so settle_tmr+1 cannot wrap. It is true
  // immediately for settle values of 0 and 1.
  always_comb begin
    per_last   = per_q - ONE_T;
    step_fire  = (state == RAMP) && (step_tmr == per_last);
    reached    = (step_next == tgt_q);
    settle_end = ({1'b0, settle_tmr} + ONE_T1) >= {1'b0, set_q};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Abort wins over start. Start applies in every state;
  // in SETTLE it acts as a retarget. A start whose target equals the current
  // code goes straight to SETTLE.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else if (start) begin
      next_state = (target == dac_code) ? SETTLE : RAMP;
    end else begin
      case (state)
        RAMP: begin
          if (step_fire && reached) begin
            next_state = SETTLE;
          end
        end
        SETTLE: begin
          if (settle_end) begin
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath registers: latched request, code, timers and the done pulse.
  // An abort holds the code where it is. The code only changes on a step
  // inside RAMP, so IDLE and SETTLE never move it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q      <= '0;
      up_q       <= '0;
      dn_q       <= '0;
      per_q      <= '0;
      set_q      <= '0;
      step_tmr   <= '0;
      settle_tmr <= '0;
      dac_code   <= '0;
      done       <= 1'b0;
      dir        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        step_tmr   <= '0;
        settle_tmr <= '0;
      end else if (start) begin
        tgt_q      <= target;
        up_q       <= (step_up == '0) ? ONE_W : step_up;
        dn_q       <= (step_dn == '0) ? ONE_W : step_dn;
        per_q      <= (period == '0) ? ONE_T : period;
        set_q      <= settle;
        dir        <= (target > dac_code);
        step_tmr   <= '0;
        settle_tmr <= '0;
      end else begin
        case (state)
          RAMP: begin
            if (step_fire) begin
              dac_code   <= step_next;
              step_tmr   <= '0;
              settle_tmr <= '0;
            end else begin
              step_tmr <= step_tmr + ONE_T;
            end
          end
          SETTLE: begin
            if (settle_end) begin
              done <= 1'b1;
            end else begin
              settle_tmr <= settle_tmr + ONE_T;
            end
          end
          default: begin
            step_tmr   <= '0;
            settle_tmr <= '0;
          end
        endcase
      end
    end
  end

`ifdef SLEW_RAMP_CTRL_CROSS_EN
  // Threshold crossing detector. It checks only the code transition a step
  // actually makes. Upward: old < thr <= new. Downward: old >= thr > new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cross_evt <= 1'b0;
      cross_dir <= 1'b0;
    end else begin
      cross_evt <= 1'b0;
      if (!abort && !start && step_fire) begin
        if ((dac_code < cross_thr) && (cross_thr <= step_next)) begin
          cross_evt <= 1'b1;
          cross_dir <= 1'b1;
        end else if ((dac_code >= cross_thr) && (cross_thr > step_next)) begin
          cross_evt <= 1'b1;
          cross_dir <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_slew_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_slew_ramp_ctrl
//
// Directed testbench for slew_ramp_ctrl with the default parameters
// (WIDTH=12, TW=8). Inputs are driven and outputs are sampled 1 ns after each
// rising clock edge. Every expected value is computed by hand from the
// intended ramp behaviour.
// -----------------------------------------------------------------------------
module tb_slew_ramp_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [11:0] target;
  logic [11:0] step_up;
  logic [11:0] step_dn;
  logic [7:0]  period;
  logic [7:0]  settle;
  logic [11:0] dac_code;
  logic        busy;
  logic        done;
  logic        dir;
`ifdef SLEW_RAMP_CTRL_CROSS_EN
  logic [11:0] cross_thr;
  logic        cross_evt;
  logic        cross_dir;
`endif

  int testCount;
  int failCount;

  slew_ramp_ctrl #(.WIDTH(12), .TW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .target   (target),
    .step_up  (step_up),
    .step_dn  (step_dn),
    .period   (period),
    .settle   (settle),
`ifdef SLEW_RAMP_CTRL_CROSS_EN
    .cross_thr(cross_thr),
    .cross_evt(cross_evt),
    .cross_dir(cross_dir),
`endif
    .dac_code (dac_code),
    .busy     (busy),
    .done     (done),
    .dir      (dir)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle 1 ns past the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a one-cycle start request carrying the given parameters
  task automatic applyStimulus(input logic [11:0] tgt, input logic [11:0] up,
                               input logic [11:0] dn, input logic [7:0] per,
                               input logic [7:0] set);
    target  = tgt;
    step_up = up;
    step_dn = dn;
    period  = per;
    settle  = set;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    target  = '0;
    step_up = '0;
    step_dn = '0;
    period  = '0;
    settle  = '0;
`ifdef SLEW_RAMP_CTRL_CROSS_EN
    cross_thr = 12'd6;
`endif

    // Reset state
    #12;
    checkOutput("rst_code", dac_code, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_dir", dir, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);

    // Rising ramp 0 -> 10, step 4, period 1, settle 2
    applyStimulus(12'd10, 12'd4, 12'd1, 8'd1, 8'd2);
    checkOutput("up_e0_code", dac_code, 0);
    checkOutput("up_e0_busy", busy, 1);
    checkOutput("up_e0_dir", dir, 1);
    tick(1);
    checkOutput("up_e1_code", dac_code, 4);
`ifdef SLEW_RAMP_CTRL_CROSS_EN
    checkOutput("cross_e1_evt", cross_evt, 0);
`endif
    tick(1);
    checkOutput("up_e2_code", dac_code, 8);
`ifdef SLEW_RAMP_CTRL_CROSS_EN
    checkOutput("cross_e2_evt", cross_evt, 1);
    checkOutput("cross_e2_dir", cross_dir, 1);
`endif
    tick(1);
    checkOutput("up_e3_code", dac_code, 10);
    checkOutput("up_e3_busy", busy, 1);
    checkOutput("up_e3_done", done, 0);
`ifdef SLEW_RAMP_CTRL_CROSS_EN
    checkOutput("cross_e3_evt", cross_evt, 0);
`endif
    tick(1);
    checkOutput("up_settle2_busy", busy, 1);
    checkOutput("up_settle2_done", done, 0);
    tick(1);
    checkOutput("up_end_busy", busy, 0);
    checkOutput("up_end_done", done, 1);
    checkOutput("up_end_code", dac_code, 10);
    tick(1);
    checkOutput("up_done_pulse", done, 0);

    // Falling ramp 10 -> 3, step 5, period 3, settle 0
    applyStimulus(12'd3, 12'd1, 12'd5, 8'd3, 8'd0);
    checkOutput("dn_e0_dir", dir, 0);
    tick(2);
    checkOutput("dn_e2_code", dac_code, 10);
    tick(1);
    checkOutput("dn_e3_code", dac_code, 5);
    tick(2);
    checkOutput("dn_e5_code", dac_code, 5);
    tick(1);
    checkOutput("dn_e6_code", dac_code, 3);
    checkOutput("dn_e6_dir", dir, 0);
    checkOutput("dn_e6_busy", busy, 1);
    tick(1);
    checkOutput("dn_e7_done", done, 1);
    checkOutput("dn_e7_busy", busy, 0);

    // Wide steps clamp at the target without wrapping or underflowing
    applyStimulus(12'd4090, 12'd4095, 12'd1, 8'd1, 8'd0);
    tick(2);
    checkOutput("clamp_4090", dac_code, 4090);
    applyStimulus(12'd4095, 12'd4000, 12'd1, 8'd1, 8'd0);
    tick(2);
    checkOutput("nowrap_4095", dac_code, 4095);
    applyStimulus(12'd5, 12'd1, 12'd4095, 8'd1, 8'd0);
    tick(2);
    checkOutput("clamp_5", dac_code, 5);
    applyStimulus(12'd0, 12'd1, 12'd100, 8'd1, 8'd0);
    tick(1);
    checkOutput("nounder_0", dac_code, 0);
    tick(1);

    // Zero step and zero period behave as 1
    applyStimulus(12'd2, 12'd0, 12'd0, 8'd0, 8'd0);
    tick(1);
    checkOutput("zero_step_e1", dac_code, 1);
    tick(1);
    checkOutput("zero_step_e2", dac_code, 2);
    tick(2);

    // Abort with start in the same cycle mid-ramp at code 8
    applyStimulus(12'd20, 12'd2, 12'd1, 8'd1, 8'd0);
    tick(3);
    checkOutput("abort_pre_code", dac_code, 8);
    abort  = 1'b1;
    start  = 1'b1;
    target = 12'd0;
    tick(1);
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_code", dac_code, 8);
    checkOutput("abort_done", done, 0);
    tick(2);
    checkOutput("idle_hold_code", dac_code, 8);
    checkOutput("idle_no_done", done, 0);

    // Asynchronous reset mid-ramp
    applyStimulus(12'd100, 12'd3, 12'd1, 8'd1, 8'd0);
    tick(2);
    checkOutput("pre_rst_code", dac_code, 14);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_code", dac_code, 0);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_dir", dir, 0);
    tick(1);
    checkOutput("rst_hold_done", done, 0);
    rst_n = 1'b1;
    tick(1);
    checkOutput("post_rst_done", done, 0);

    // Start with target equal to the current code goes straight to SETTLE
    applyStimulus(12'd0, 12'd1, 12'd1, 8'd1, 8'd3);
    checkOutput("eq_e0_busy", busy, 1);
    checkOutput("eq_e0_code", dac_code, 0);
    tick(2);
    checkOutput("eq_e2_busy", busy, 1);
    checkOutput("eq_e2_done", done, 0);
    tick(1);
    checkOutput("eq_e3_done", done, 1);
    checkOutput("eq_e3_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
